// File: rtl/sound_pkg.sv
// Shared constants for the sound mixer: register bit positions, datapath widths
// and the per-side panning sum helper.
package sound_pkg;

  localparam int PCM_W     = 16;
  localparam int LEVEL_W   = 4;
  localparam int NUM_CH    = 4;
  localparam int SUM_W     = 6;   // 4 channels * 15 = 60
  localparam int MIX_W     = 9;   // 60 * 8 = 480
  localparam int MIX_SHIFT = 6;   // 480 << 6 = 30720

  localparam int NR51_LEFT_LSB  = 4;
  localparam int NR51_RIGHT_LSB = 0;
  localparam int NR50_LEFT_LSB  = 4;
  localparam int NR50_RIGHT_LSB = 0;
  localparam int NR50_VOL_W     = 3;

  // Sum of the levels whose route bit is set; bit n selects channel n+1.
  function automatic logic [SUM_W-1:0] pan_sum(
    input logic [NUM_CH*LEVEL_W-1:0] levels,
    input logic [NUM_CH-1:0]         route
  );
    logic [SUM_W-1:0] acc;
    acc = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (route[n]) acc = acc + SUM_W'(levels[n*LEVEL_W +: LEVEL_W]);
    end
    return acc;
  endfunction

endpackage

// File: rtl/sound_dc_block.sv
// First-order DC-blocking high-pass for one output side:
// y = x - x_prev + y_prev - (y_prev >>> DC_SHIFT), saturated to signed 16 bits.
module sound_dc_block import sound_pkg::*; #(
  parameter int DC_SHIFT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [PCM_W-1:0] x,
  output logic [PCM_W-1:0] y
);

  localparam int ACC_W = PCM_W + 2;
  localparam logic signed [ACC_W-1:0] SAT_HI = 32767;
  localparam logic signed [ACC_W-1:0] SAT_LO = -32768;

  logic [PCM_W-1:0]        x_prev, y_prev, y_sat;
  logic signed [ACC_W-1:0] x_ext, xp_ext, yp_ext, acc;

  always_comb begin
    x_ext  = $signed({2'b00, x});
    xp_ext = $signed({2'b00, x_prev});
    yp_ext = $signed({{2{y_prev[PCM_W-1]}}, y_prev});
    acc    = x_ext - xp_ext + yp_ext - (yp_ext >>> DC_SHIFT);
    if (acc > SAT_HI)      y_sat = 16'h7fff;
    else if (acc < SAT_LO) y_sat = 16'h8000;
    else                   y_sat = acc[PCM_W-1:0];
  end

  assign y = clear ? '0 : y_sat;

  // Muting holds the state at zero so the filter restarts cleanly on unmute.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      x_prev <= '0;
      y_prev <= '0;
    end else if (load) begin
      x_prev <= x;
      y_prev <= y_sat;
    end
  end

endmodule

// File: rtl/sound_mixer.sv
// Four-channel stereo mixer: NR51 panning, NR50 master volume, optional DC
// blocking, and a fixed-rate valid/ready PCM output with a sticky overrun flag.
module sound_mixer import sound_pkg::*; #(
  parameter int CLK_DIV  = 87,
  parameter bit DC_BLOCK = 1'b1,
  parameter int DC_SHIFT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ch1_level,
  input  logic [3:0]  ch2_level,
  input  logic [3:0]  ch3_level,
  input  logic [3:0]  ch4_level,
  input  logic [3:0]  ch_enable,
  input  logic [7:0]  nr51,
  input  logic [7:0]  nr50,
  input  logic        master_en,
  output logic [15:0] out_left,
  output logic [15:0] out_right,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overrun,
  input  logic        overrun_clr
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0]          cnt;
  logic                      tick, s1_valid, s2_valid;
  logic [NUM_CH*LEVEL_W-1:0] levels;
  logic [NUM_CH-1:0]         route_l, route_r;
  logic [SUM_W-1:0]          sum_l, sum_r;
  logic [NR50_VOL_W:0]       vol_l, vol_r;
  logic [MIX_W-1:0]          mix_l, mix_r;
  logic [PCM_W-1:0]          x_l, x_r, y_l, y_r;
  logic                      unused_nr50;

  assign unused_nr50 = ^{nr50[7], nr50[3]};

  assign tick    = (cnt == CNT_LAST);
  assign levels  = {ch4_level, ch3_level, ch2_level, ch1_level};
  assign route_l = ch_enable & nr51[NR51_LEFT_LSB  +: NUM_CH];
  assign route_r = ch_enable & nr51[NR51_RIGHT_LSB +: NUM_CH];
  assign vol_l   = {1'b0, nr50[NR50_LEFT_LSB  +: NR50_VOL_W]} + 4'd1;
  assign vol_r   = {1'b0, nr50[NR50_RIGHT_LSB +: NR50_VOL_W]} + 4'd1;
  assign mix_l   = MIX_W'(sum_l) * MIX_W'(vol_l);
  assign mix_r   = MIX_W'(sum_r) * MIX_W'(vol_r);

  // NOTE: all state uses non-blocking assignment so every stage samples the
  // previous stage's value from before the edge, never the one being written.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      sum_l    <= '0;
      sum_r    <= '0;
      x_l      <= '0;
      x_r      <= '0;
    end else begin
      cnt      <= tick ? '0 : cnt + CNT_W'(1);
      s1_valid <= tick;
      s2_valid <= s1_valid;
      if (tick) begin
        sum_l <= master_en ? pan_sum(levels, route_l) : '0;
        sum_r <= master_en ? pan_sum(levels, route_r) : '0;
      end
      if (s1_valid) begin
        x_l <= PCM_W'(mix_l) << MIX_SHIFT;
        x_r <= PCM_W'(mix_r) << MIX_SHIFT;
      end
    end
  end

  if (DC_BLOCK) begin : g_dc
    sound_dc_block #(.DC_SHIFT(DC_SHIFT)) u_left (
      .clk(clk), .rst(rst), .load(s2_valid), .clear(!master_en), .x(x_l), .y(y_l)
    );
    sound_dc_block #(.DC_SHIFT(DC_SHIFT)) u_right (
      .clk(clk), .rst(rst), .load(s2_valid), .clear(!master_en), .x(x_r), .y(y_r)
    );
  end else begin : g_bypass
    assign y_l = master_en ? x_l : '0;
    assign y_r = master_en ? x_r : '0;
  end

  // A load coinciding with a handshake replaces a consumed sample: no overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_left  <= '0;
      out_right <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (s2_valid) begin
        out_left  <= y_l;
        out_right <= y_r;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (overrun_clr)                             overrun <= 1'b0;
      else if (s2_valid && out_valid && !out_ready) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sound_mixer.sv
// Scoreboard bench for sound_mixer: a plain instance (no DC block) and a
// DC-blocking instance share channel inputs; monitors pop expected samples.
module tb_sound_mixer;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  ch1, ch2, ch3, ch4, ch_enable;
  logic [7:0]  nr51, nr50;
  logic        master_a, master_b, ready_a, ready_b, clr_a, clr_b;
  logic [15:0] left_a, right_a, left_b, right_b;
  logic        valid_a, valid_b, overrun_a, overrun_b;

  int   checks = 0;
  int   passes = 0;
  bit   mon_a = 1'b0;
  bit   mon_b = 1'b0;
  exp_t qa[$];
  exp_t qb[$];

  sound_mixer #(.CLK_DIV(8), .DC_BLOCK(1'b0), .DC_SHIFT(8)) u_plain (
    .clk(clk), .rst(rst),
    .ch1_level(ch1), .ch2_level(ch2), .ch3_level(ch3), .ch4_level(ch4),
    .ch_enable(ch_enable), .nr51(nr51), .nr50(nr50), .master_en(master_a),
    .out_left(left_a), .out_right(right_a), .out_valid(valid_a),
    .out_ready(ready_a), .overrun(overrun_a), .overrun_clr(clr_a)
  );

  sound_mixer #(.CLK_DIV(8), .DC_BLOCK(1'b1), .DC_SHIFT(4)) u_dc (
    .clk(clk), .rst(rst),
    .ch1_level(ch1), .ch2_level(ch2), .ch3_level(ch3), .ch4_level(ch4),
    .ch_enable(ch_enable), .nr51(nr51), .nr50(nr50), .master_en(master_b),
    .out_left(left_b), .out_right(right_b), .out_valid(valid_b),
    .out_ready(ready_b), .overrun(overrun_b), .overrun_clr(clr_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Returns one time unit after the negedge at which the chosen DUT shows a sample.
  task automatic wait_sample(input bit dc, input string name);
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (dc ? valid_b : valid_a) return;
    end
    checks++;
    $display("FAIL %s: no sample within 40 cycles", name);
  endtask

  task automatic push_a(input int l, input int r);
    qa.push_back('{l: 16'(l), r: 16'(r)});
  endtask

  task automatic push_b(input int l, input int r);
    qb.push_back('{l: 16'(l), r: 16'(r)});
  endtask

  initial begin : monitor_a
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_a && valid_a && ready_a) begin
        if (qa.size() == 0) begin
          checks++;
          $display("FAIL plain_unexpected: got sample %0d/%0d expected none", left_a, right_a);
        end else begin
          e = qa.pop_front();
          check("plain_left", left_a, e.l);
          check("plain_right", right_a, e.r);
        end
      end
    end
  end

  initial begin : monitor_b
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_b && valid_b && ready_b) begin
        if (qb.size() == 0) begin
          checks++;
          $display("FAIL dc_unexpected: got sample %0d/%0d expected none", left_b, right_b);
        end else begin
          e = qb.pop_front();
          check("dc_left", left_b, e.l);
          check("dc_right", right_b, e.r);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    int cyc;
    rst = 1'b1;
    {ch1, ch2, ch3, ch4} = {4'd15, 4'd15, 4'd15, 4'd15};
    ch_enable = 4'hf;
    nr51 = 8'hf0;
    nr50 = 8'h70;
    master_a = 1'b1;
    master_b = 1'b0;
    ready_a = 1'b1;
    ready_b = 1'b1;
    clr_a = 1'b0;
    clr_b = 1'b0;

    step(3);
    check("rst_valid_a", valid_a, 0);
    check("rst_valid_b", valid_b, 0);
    check("rst_overrun_a", overrun_a, 0);
    check("rst_overrun_b", overrun_b, 0);
    check("rst_left_a", left_a, 0);
    check("rst_right_a", right_a, 0);
    check("rst_left_b", left_b, 0);
    check("rst_right_b", right_b, 0);

    // Full left pan, volume 8: 60 * 8 << 6.
    push_a(30720, 0);
    push_a(30720, 0);
    mon_a = 1'b1;
    rst = 1'b0;

    // Tick in cycle 8, output register loads on the 10th rising edge.
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      cyc++;
      if (valid_a) break;
    end
    check("first_valid_cycle", 32'(cyc), 10);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      cyc++;
      if (valid_a) break;
    end
    check("sample_period", 32'(cyc), 8);

    // Left ch2 at vol 2, right ch1 at vol 3.
    ch1 = 4'd5; ch2 = 4'd3; nr51 = 8'h21; nr50 = 8'h12;
    push_a(384, 960);
    wait_sample(1'b0, "vec_pan");

    // Disabled ch1 contributes nothing.
    ch_enable = 4'b1110; ch1 = 4'd15; nr51 = 8'h11; nr50 = 8'h00;
    push_a(0, 0);
    wait_sample(1'b0, "vec_disabled");

    // All channels both sides, max volume: (1+2+3+4) * 8 << 6.
    ch_enable = 4'hf; {ch4, ch3, ch2, ch1} = {4'd4, 4'd3, 4'd2, 4'd1};
    nr51 = 8'hff; nr50 = 8'h77;
    push_a(5120, 5120);
    wait_sample(1'b0, "vec_all");

    // Bits 7 and 3 of NR50 ignored; left routes ch4 only.
    nr51 = 8'h8f; nr50 = 8'h88;
    push_a(256, 640);
    wait_sample(1'b0, "vec_ignored_bits");

    master_a = 1'b0;
    push_a(0, 0);
    wait_sample(1'b0, "vec_master_off");

    // Backpressure: single channel, volume 1, out = ch1 * 64 on both sides.
    master_a = 1'b1; ch1 = 4'd1; nr51 = 8'h11; nr50 = 8'h00;
    step(1);
    ready_a = 1'b0;
    wait_sample(1'b0, "bp_first");
    ch1 = 4'd2;
    step(8);
    check("bp_overrun_set", overrun_a, 1);
    check("bp_overwrite_left", left_a, 128);
    check("bp_overwrite_valid", valid_a, 1);
    ch1 = 4'd3; clr_a = 1'b1;
    step(8);
    check("bp_clr_beats_set", overrun_a, 0);
    check("bp_third_left", left_a, 192);
    clr_a = 1'b0; ch1 = 4'd4;
    step(8);
    check("bp_overrun_again", overrun_a, 1);
    check("bp_fourth_right", right_a, 256);
    push_a(256, 256);
    ch1 = 4'd5; clr_a = 1'b1;
    step(1);
    check("bp_clr_alone", overrun_a, 0);
    clr_a = 1'b0;
    push_a(320, 320);
    step(6);
    ready_a = 1'b1;
    step(1);
    check("bp_ready_in_load", overrun_a, 0);
    step(1);
    mon_a = 1'b0;

    // DC blocker, DC_SHIFT=4, constant x = 30720 on both sides.
    wait_sample(1'b1, "dc_sync");
    {ch4, ch3, ch2, ch1} = {4'd15, 4'd15, 4'd15, 4'd15};
    nr51 = 8'hff; nr50 = 8'h77; master_b = 1'b1;
    push_b(30720, 30720);
    push_b(28800, 28800);
    push_b(27000, 27000);
    push_b(25313, 25313);
    step(1);
    mon_b = 1'b1;
    for (int i = 0; i < 4; i++) wait_sample(1'b1, "dc_decay");

    master_b = 1'b0;
    push_b(0, 0);
    wait_sample(1'b1, "dc_mute");
    master_b = 1'b1;
    push_b(30720, 30720);
    push_b(28800, 28800);
    wait_sample(1'b1, "dc_restart0");
    wait_sample(1'b1, "dc_restart1");

    // Reset lands in cycle t+2 of the next sample, while it sits in S2.
    step(7);
    rst = 1'b1;
    step(1);
    check("midrst_valid", valid_b, 0);
    check("midrst_left", left_b, 0);
    check("midrst_overrun", overrun_b, 0);
    rst = 1'b0;
    push_b(30720, 30720);
    push_b(28800, 28800);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      cyc++;
      if (valid_b) break;
    end
    check("midrst_first_valid", 32'(cyc), 10);
    wait_sample(1'b1, "midrst_second");
    step(2);

    check("plain_queue_drained", 32'(qa.size()), 0);
    check("dc_queue_drained", 32'(qb.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
